// File: rtl/random_move_gen.sv
// rtl/random_move_gen.sv - LFSR-driven move code generator for the grid wanderer
module random_move_gen #(
   parameter logic [15:0] SEED          = 16'hACE1,
   parameter logic [15:0] TAPS          = 16'hB400,
   parameter int          STEP_DIV      = 4,
   parameter logic [3:0]  STRAIGHT_BIAS = 4'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        seed_load,
   input  logic [15:0] seed_value,
   output logic [1:0]  nextMove,
   output logic        move_valid,
   output logic [15:0] move_count
);

   typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

   localparam logic [15:0] LAST_CNT = 16'(STEP_DIV - 1);
   // Bit i is set when lfsr[7:4]==i should force a straight move (i < STRAIGHT_BIAS).
   // A lookup avoids a constant-false compare when the bias is zero.
   localparam logic [15:0] BIAS_MASK = 16'((32'd1 << STRAIGHT_BIAS) - 32'd1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [1:0]  next_move_q, next_move_d;   // also serves as the last emitted move
   logic        have_moved_q, have_moved_d;
   logic        move_valid_q, move_valid_d;
   logic [15:0] move_count_q, move_count_d;

   logic [15:0] lfsr_step;
   logic [1:0]  raw;
   logic [1:0]  cand;

   // State register: every flop, with synchronous reset taking priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= 16'd0;
         lfsr_q       <= SEED;
         next_move_q  <= 2'b00;
         have_moved_q <= 1'b0;
         move_valid_q <= 1'b0;
         move_count_q <= 16'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lfsr_q       <= lfsr_d;
         next_move_q  <= next_move_d;
         have_moved_q <= have_moved_d;
         move_valid_q <= move_valid_d;
         move_count_q <= move_count_d;
      end
   end

   // Next-state: run the cadence only while enable is held high.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable)  state_d = COUNT;
         COUNT:   if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // LFSR: a seed load wins over the advance; a zero seed would lock the LFSR, so substitute SEED.
   always_comb begin
      lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
      lfsr_d    = lfsr_q;
      if (seed_load) begin
         lfsr_d = (seed_value == 16'h0000) ? SEED : seed_value;
      end else if (enable) begin
         lfsr_d = lfsr_step;
      end
   end

   // Candidate move from the pre-advance LFSR: optional straight bias, reversals turned perpendicular.
   always_comb begin
      raw  = lfsr_q[1:0];
      cand = raw;
      if (have_moved_q && BIAS_MASK[lfsr_q[7:4]]) begin
         cand = next_move_q;
      end else if (have_moved_q && (raw == (next_move_q ^ 2'b01))) begin
         cand = raw ^ 2'b10;
      end
   end

   // Outputs: step counter, and on the final count the emit of a new move with a one-cycle pulse.
   always_comb begin
      cnt_d        = 16'd0;
      move_valid_d = 1'b0;
      next_move_d  = next_move_q;
      have_moved_d = have_moved_q;
      move_count_d = move_count_q;
      if ((state_q == COUNT) && enable) begin
         if (cnt_q == LAST_CNT) begin
            move_valid_d = 1'b1;
            next_move_d  = cand;
            have_moved_d = 1'b1;
            move_count_d = move_count_q + 16'd1;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end
   end

   assign nextMove   = next_move_q;
   assign move_valid = move_valid_q;
   assign move_count = move_count_q;

endmodule

// File: tb/tb_random_move_gen.sv
// tb/tb_random_move_gen.sv - directed bench for random_move_gen
module tb_random_move_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        seed_load;
   logic [15:0] seed_value;
   logic [1:0]  next_move,  next_move_b;
   logic        move_valid, move_valid_b;
   logic [15:0] move_count, move_count_b;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   random_move_gen dut (
      .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed_value(seed_value),
      .nextMove(next_move), .move_valid(move_valid), .move_count(move_count)
   );

   random_move_gen #(.STRAIGHT_BIAS(4'd15)) dut_b (
      .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed_value(seed_value),
      .nextMove(next_move_b), .move_valid(move_valid_b), .move_count(move_count_b)
   );

   typedef struct {
      logic        rst;
      logic        en;
      logic        sl;
      logic [15:0] sv;
      logic        ev;
      logic [1:0]  em;
      logic [15:0] ec;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic en, input logic ev, input logic [1:0] em,
                      input logic [15:0] ec);
      vec_t v;
      v.rst = rst; v.en = en; v.sl = 1'b0; v.sv = 16'h0000;
      v.ev = ev; v.em = em; v.ec = ec;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic rst, input logic en, input logic sl, input logic [15:0] sv);
      reset = rst; enable = en; seed_load = sl; seed_value = sv;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] m_step(input logic [15:0] l);
      return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [1:0] m_pick(input logic [15:0] l, input bit have, input logic [1:0] last,
                                         input int bias);
      logic [1:0] r;
      r = l[1:0];
      if (have && (int'(l[7:4]) < bias)) return last;
      if (have && (r == (last ^ 2'b01))) return r ^ 2'b10;
      return r;
   endfunction

   // Reference state for the long run on dut (bias 0)
   logic [15:0] m_lfsr;
   logic [1:0]  m_last;
   bit          m_have;
   logic [15:0] m_count;
   logic [3:0]  seen;

   task automatic tick_chk(input logic sl, input logic [15:0] sv, input bit emit);
      logic [1:0] exp_move;
      logic [1:0] prev_move;
      exp_move  = m_last;
      prev_move = next_move;
      if (emit) begin
         exp_move = m_pick(m_lfsr, m_have, m_last, 0);
         m_last   = exp_move;
         m_have   = 1'b1;
         m_count  = m_count + 16'd1;
      end
      if (sl) m_lfsr = (sv == 16'h0000) ? 16'hACE1 : sv;
      else    m_lfsr = m_step(m_lfsr);
      cyc(1'b0, 1'b1, sl, sv);
      chk("run_valid", {15'd0, move_valid}, {15'd0, emit});
      if (emit) begin
         chk("run_move", {14'd0, next_move}, {14'd0, exp_move});
         chk("run_count", move_count, m_count);
         if (m_count > 16'd1) chk("no_reversal", {15'd0, ((next_move ^ prev_move) == 2'b01)}, 16'd0);
         seen[next_move] = 1'b1;
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; seed_load = 1'b0; seed_value = 16'h0000;

      // Table: reset, idle, cadence from SEED, enable drop/re-raise, reset mid-count.
      for (int i = 0; i < 3; i++)  add(1, 0, 0, 2'b00, 16'd0);
      for (int i = 0; i < 20; i++) add(0, 0, 0, 2'b00, 16'd0);
      for (int i = 0; i < 4; i++)  add(0, 1, 0, 2'b00, 16'd0);
      add(0, 1, 1, 2'b10, 16'd1);                              // lfsr 1C4E
      for (int i = 0; i < 3; i++)  add(0, 1, 0, 2'b10, 16'd1);
      add(0, 1, 1, 2'b00, 16'd2);                              // lfsr C2C4
      for (int i = 0; i < 3; i++)  add(0, 1, 0, 2'b00, 16'd2);
      add(0, 1, 1, 2'b00, 16'd3);                              // lfsr 562C
      for (int i = 0; i < 2; i++)  add(0, 1, 0, 2'b00, 16'd3); // cnt 1, 2
      for (int i = 0; i < 5; i++)  add(0, 0, 0, 2'b00, 16'd3); // dropped at cnt==2
      for (int i = 0; i < 4; i++)  add(0, 1, 0, 2'b00, 16'd3);
      add(0, 1, 1, 2'b00, 16'd4);                              // lfsr 476C
      for (int i = 0; i < 2; i++)  add(0, 1, 0, 2'b00, 16'd4);
      add(1, 1, 0, 2'b00, 16'd0);                              // reset mid-count
      add(0, 0, 0, 2'b00, 16'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         cyc(vecs[i].rst, vecs[i].en, vecs[i].sl, vecs[i].sv);
         chk($sformatf("vec%0d_valid", i), {15'd0, move_valid}, {15'd0, vecs[i].ev});
         chk($sformatf("vec%0d_move", i), {14'd0, next_move}, {14'd0, vecs[i].em});
         chk($sformatf("vec%0d_count", i), move_count, vecs[i].ec);
      end

      // Zero seed falls back to SEED; then 2000 moves against the reference.
      cyc(1'b1, 1'b0, 1'b0, 16'h0000);
      cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      cyc(1'b0, 1'b0, 1'b1, 16'h0000);
      chk("seed_zero_lfsr", dut.lfsr_q, 16'hACE1);
      m_lfsr = 16'hACE1; m_last = 2'b00; m_have = 1'b0; m_count = 16'd0; seen = 4'b0000;
      for (int j = 0; j <= 8000; j++) tick_chk(1'b0, 16'h0000, (j != 0) && (j % 4 == 0));
      chk("all_codes_seen", {12'd0, seen}, 16'h000F);

      // Seed load on an emit edge: move uses the old LFSR, LFSR takes the new seed.
      for (int j = 1; j <= 3; j++) tick_chk(1'b0, 16'h0000, 1'b0);
      tick_chk(1'b1, 16'h1234, 1'b1);
      for (int j = 1; j <= 8; j++) tick_chk(1'b0, 16'h0000, (j % 4 == 0));

      // Seed 0010: first move 01 on both; second is perpendicular (bias 0) or straight (bias 15).
      cyc(1'b1, 1'b0, 1'b0, 16'h0000);
      cyc(1'b0, 1'b0, 1'b1, 16'h0010);
      for (int j = 0; j <= 8; j++) begin
         cyc(1'b0, 1'b1, 1'b0, 16'h0000);
         if (j == 4) begin
            chk("s10_first_move", {14'd0, next_move}, 16'd1);
            chk("s10_first_move_b", {14'd0, next_move_b}, 16'd1);
            chk("s10_first_valid_b", {15'd0, move_valid_b}, 16'd1);
         end
         if (j == 8) begin
            chk("s10_perpendicular", {14'd0, next_move}, 16'd2);
            chk("s10_straight_b", {14'd0, next_move_b}, 16'd1);
            chk("s10_count_b", move_count_b, 16'd2);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
